// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions: operand-use encodings, exception vector and
// the MDU sequencer state encoding.
package pipe_stall_ctrl_pkg;

    localparam logic [1:0]  TUSE_NONE  = 2'd3;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mdu_busy_cnt.sv
// MDU busy countdown: loads the op latency on an accepted start and holds
// busy_o high for exactly that many cycles.
module mdu_busy_cnt
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    input  logic req_i,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // An exception only blocks a new start; an op already running must still
    // commit HI/LO, so the countdown ignores req_i once in MDU_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (start_i && !req_i) begin
                        cnt_q   <= is_div_i ? DIV_LOAD : MULT_LOAD;
                        state_q <= MDU_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    // The D-stage MDU stall keeps a second start out of E while busy.
    assert property (@(posedge clk) disable iff (reset)
                     !(state_q == MDU_WAIT && start_i));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives the F/D enables and
// E/M/W clears from operand hazards, the MDU busy window and exceptions.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic       D_is_mdu,
    input  logic [4:0] E_waddr,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_waddr,
    input  logic [1:0] M_tnew,
    input  logic       E_mdu_start,
    input  logic       E_mdu_div,
    output logic       F_en,
    output logic       D_en,
    output logic       E_clr,
    output logic       M_clr,
    output logic       W_clr,
    output logic       mdu_busy,
    output logic       stall
);

    logic busy;
    logic rs_used, rt_used;
    logic stall_rs, stall_rt, stall_mdu, stall_raw;

    mdu_busy_cnt #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mdu_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .start_i (E_mdu_start),
        .is_div_i(E_mdu_div),
        .req_i   (req),
        .busy_o  (busy)
    );

    assign mdu_busy = busy;

    // A register index of 0 is $0, which never carries a pending result.
    assign rs_used  = (D_rs != 5'd0) && (D_rs_tuse != TUSE_NONE);
    assign rt_used  = (D_rt != 5'd0) && (D_rt_tuse != TUSE_NONE);

    assign stall_rs = rs_used &&
                      (((D_rs == E_waddr) && (E_tnew > D_rs_tuse)) ||
                       ((D_rs == M_waddr) && (M_tnew > D_rs_tuse)));
    assign stall_rt = rt_used &&
                      (((D_rt == E_waddr) && (E_tnew > D_rt_tuse)) ||
                       ((D_rt == M_waddr) && (M_tnew > D_rt_tuse)));

    assign stall_mdu = D_is_mdu && (busy || E_mdu_start);
    assign stall_raw = (stall_rs || stall_rt || stall_mdu) && !req;

    // Priority: reset flush, then exception flush, then hazard stall.
    always_comb begin
        F_en  = 1'b1;
        D_en  = 1'b1;
        E_clr = 1'b0;
        M_clr = 1'b0;
        W_clr = 1'b0;
        stall = 1'b0;
        if (reset) begin
            F_en  = 1'b0;
            D_en  = 1'b0;
            E_clr = 1'b1;
            M_clr = 1'b1;
            W_clr = 1'b1;
        end else if (req) begin
            E_clr = 1'b1;
            M_clr = 1'b1;
            W_clr = 1'b1;
        end else if (stall_raw) begin
            F_en  = 1'b0;
            D_en  = 1'b0;
            E_clr = 1'b1;
            stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed hazard/MDU/exception
// scenarios followed by randomized cycles against a cycle-count model.
module tb_pipe_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset, req, D_is_mdu, E_mdu_start, E_mdu_div;
    logic [4:0] D_rs, D_rt, E_waddr, M_waddr;
    logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic       F_en, D_en, E_clr, M_clr, W_clr, mdu_busy, stall;

    int    testCount = 0;
    int    failCount = 0;
    int    busyLeft  = 0;
    int    busyCycles, stallCycles;
    logic  sawBusy, sawStall;
    string phase = "init";

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_rs_tuse  (D_rs_tuse),
        .D_rt_tuse  (D_rt_tuse),
        .D_is_mdu   (D_is_mdu),
        .E_waddr    (E_waddr),
        .E_tnew     (E_tnew),
        .M_waddr    (M_waddr),
        .M_tnew     (M_tnew),
        .E_mdu_start(E_mdu_start),
        .E_mdu_div  (E_mdu_div),
        .F_en       (F_en),
        .D_en       (D_en),
        .E_clr      (E_clr),
        .M_clr      (M_clr),
        .W_clr      (W_clr),
        .mdu_busy   (mdu_busy),
        .stall      (stall)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s/%s: observed %0h, expected %0h",
                     phase, tag, observed, expected);
        end
    endtask

    // A source operand waits when a younger-stage producer needs more cycles
    // than the consumer can tolerate; $0 never waits.
    function automatic bit readWaits(input logic [4:0] src, input logic [1:0] tuse);
        int need = int'(tuse);
        if (src == 5'd0) return 1'b0;
        if (src == E_waddr && int'(E_tnew) > need) return 1'b1;
        if (src == M_waddr && int'(M_tnew) > need) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clearInputs();
        reset       = 1'b0;
        req         = 1'b0;
        D_rs        = 5'd0;
        D_rt        = 5'd0;
        D_rs_tuse   = 2'd3;
        D_rt_tuse   = 2'd3;
        D_is_mdu    = 1'b0;
        E_waddr     = 5'd0;
        E_tnew      = 2'd0;
        M_waddr     = 5'd0;
        M_tnew      = 2'd0;
        E_mdu_start = 1'b0;
        E_mdu_div   = 1'b0;
    endtask

    task automatic applyStimulus();
        reset       = ($urandom_range(0, 49) == 0);
        req         = ($urandom_range(0, 7) == 0);
        D_rs        = 5'($urandom_range(0, 3));
        D_rt        = 5'($urandom_range(0, 3));
        D_rs_tuse   = 2'($urandom_range(0, 3));
        D_rt_tuse   = 2'($urandom_range(0, 3));
        D_is_mdu    = ($urandom_range(0, 2) == 0);
        E_waddr     = 5'($urandom_range(0, 3));
        E_tnew      = 2'($urandom_range(0, 3));
        M_waddr     = 5'($urandom_range(0, 3));
        M_tnew      = 2'($urandom_range(0, 3));
        E_mdu_start = (busyLeft == 0) && ($urandom_range(0, 5) == 0);
        E_mdu_div   = 1'($urandom_range(0, 1));
    endtask

    // Checks all outputs mid-cycle, then advances the model across the edge.
    task automatic runCycle();
        bit busy, waits, stallExp;
        #1;
        busy     = (busyLeft > 0);
        waits    = readWaits(D_rs, D_rs_tuse) || readWaits(D_rt, D_rt_tuse) ||
                   (D_is_mdu && (busy || E_mdu_start));
        stallExp = !reset && !req && waits;
        checkOutput("stall",    32'(stall),    32'(stallExp));
        checkOutput("F_en",     32'(F_en),     32'(!reset && !stallExp));
        checkOutput("D_en",     32'(D_en),     32'(!reset && !stallExp));
        checkOutput("E_clr",    32'(E_clr),    32'(reset || req || stallExp));
        checkOutput("M_clr",    32'(M_clr),    32'(reset || req));
        checkOutput("W_clr",    32'(W_clr),    32'(reset || req));
        checkOutput("mdu_busy", 32'(mdu_busy), 32'(busy));
        sawBusy  = mdu_busy;
        sawStall = stall;
        @(posedge clk);
        if (reset)
            busyLeft = 0;
        else if (busyLeft > 0)
            busyLeft = busyLeft - 1;
        else if (E_mdu_start && !req)
            busyLeft = E_mdu_div ? DIV_N : MULT_N;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clearInputs();
            runCycle();
        end
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        @(posedge clk);

        phase = "reset";
        @(negedge clk);
        runCycle();
        checkOutput("rst_F_en", 32'(F_en), 32'd0);
        checkOutput("rst_busy", 32'(sawBusy), 32'd0);

        phase = "load_use";
        @(negedge clk);
        clearInputs();
        E_waddr = 5'd1; E_tnew = 2'd2; D_rs = 5'd1; D_rs_tuse = 2'd1;
        runCycle();
        checkOutput("stall_on", 32'(sawStall), 32'd1);
        @(negedge clk);
        clearInputs();
        M_waddr = 5'd1; M_tnew = 2'd1; D_rs = 5'd1; D_rs_tuse = 2'd1;
        runCycle();
        checkOutput("stall_off", 32'(sawStall), 32'd0);

        phase = "zero_reg";
        @(negedge clk);
        clearInputs();
        E_waddr = 5'd1; E_tnew = 2'd2; D_rs = 5'd0; D_rs_tuse = 2'd1;
        runCycle();
        checkOutput("rs0", 32'(sawStall), 32'd0);
        @(negedge clk);
        clearInputs();
        E_waddr = 5'd0; E_tnew = 2'd2; D_rt = 5'd0; D_rt_tuse = 2'd0;
        runCycle();
        checkOutput("w0", 32'(sawStall), 32'd0);

        phase = "mult";
        busyCycles = 0; stallCycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clearInputs();
            D_is_mdu    = 1'b1;
            E_mdu_start = (i == 0);
            runCycle();
            busyCycles  += int'(sawBusy);
            stallCycles += int'(sawStall);
        end
        checkOutput("busy_len", 32'(busyCycles), 32'(MULT_N));
        checkOutput("stall_len", 32'(stallCycles), 32'(MULT_N + 1));

        phase = "div_req";
        busyCycles = 0;
        @(negedge clk);
        clearInputs();
        E_mdu_start = 1'b1; E_mdu_div = 1'b1;
        runCycle();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            clearInputs();
            req = (i == 2);
            runCycle();
            busyCycles += int'(sawBusy);
        end
        checkOutput("busy_len", 32'(busyCycles), 32'(DIV_N));

        phase = "req_start";
        @(negedge clk);
        clearInputs();
        req = 1'b1; E_mdu_start = 1'b1; D_is_mdu = 1'b1;
        D_rs = 5'd1; D_rs_tuse = 2'd0; E_waddr = 5'd1; E_tnew = 2'd2;
        runCycle();
        checkOutput("stall", 32'(sawStall), 32'd0);
        checkOutput("W_clr", 32'(W_clr), 32'd1);
        @(negedge clk);
        clearInputs();
        runCycle();
        checkOutput("no_busy", 32'(sawBusy), 32'd0);

        phase = "reset_mid_div";
        @(negedge clk);
        clearInputs();
        E_mdu_start = 1'b1; E_mdu_div = 1'b1;
        runCycle();
        idleCycles(4);
        @(negedge clk);
        clearInputs();
        reset = 1'b1;
        runCycle();
        checkOutput("busy_before", 32'(sawBusy), 32'd1);
        checkOutput("F_en_rst", 32'(F_en), 32'd0);
        checkOutput("E_clr_rst", 32'(E_clr), 32'd1);
        @(negedge clk);
        clearInputs();
        reset = 1'b1;
        runCycle();
        checkOutput("busy_after", 32'(sawBusy), 32'd0);
        idleCycles(2);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            applyStimulus();
            runCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
